// File: rtl/sparse_pkg.sv
// Shared definitions for the structured-sparse row scheduler.
//
// Holds the mask geometry, the per-layer field-count table, the scheduler
// state encoding, and a helper that decides whether a layer index is legal.
package sparse_pkg;

   localparam int FIELD_W    = 3;                  // mask bits per field, one per kernel column
   localparam int MAX_FIELDS = 72;                 // widest layer, in fields
   localparam int LAYERS     = 9;                  // highest legal layer index
   localparam int PTR_W      = FIELD_W * MAX_FIELDS;
   localparam int ROW_W      = 7;                  // holds 0..MAX_FIELDS
   localparam int COL_W      = 2;                  // holds 0..FIELD_W-1
   localparam int LAYER_W    = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Number of mask fields that belong to a layer; 0 for illegal layers.
   function automatic logic [ROW_W-1:0] field_count(input logic [LAYER_W-1:0] layer);
      logic [ROW_W-1:0] cnt;
      case (layer)
         4'd1:                cnt = 7'd1;
         4'd2, 4'd3, 4'd4:    cnt = 7'd36;
         4'd5, 4'd6, 4'd7:    cnt = 7'd72;
         4'd8, 4'd9:          cnt = 7'd36;
         default:             cnt = 7'd0;
      endcase
      return cnt;
   endfunction

   function automatic logic layer_legal(input logic [LAYER_W-1:0] layer);
      return (layer != '0) && (layer <= LAYER_W'(LAYERS));
   endfunction

endpackage

// File: rtl/sparse_row_scheduler_if.sv
// MAC beat bus between the row scheduler (master) and the MAC array (slave).
//
// Signals:
//   mac_valid  master->slave  a beat is presented
//   mac_ready  slave->master  beat accepted this cycle
//   mac_row    master->slave  field (kernel row) index of the beat
//   mac_col    master->slave  kernel column of the beat
//   mac_last   master->slave  final non-zero beat of the layer
interface sparse_row_scheduler_if;
   import sparse_pkg::*;

   logic             mac_valid;
   logic             mac_ready;
   logic [ROW_W-1:0] mac_row;
   logic [COL_W-1:0] mac_col;
   logic             mac_last;

   modport master (
      output mac_valid,
      output mac_row,
      output mac_col,
      output mac_last,
      input  mac_ready
   );

   modport slave (
      input  mac_valid,
      input  mac_row,
      input  mac_col,
      input  mac_last,
      output mac_ready
   );

endinterface

// File: rtl/sparse_mask_walker.sv
// Walks one 3-bit kernel-row mask, lowest column first.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   load        replace the remaining mask with load_mask (wins over pop)
//   load_mask   mask of the next field
//   pop         consume the lowest set bit
//   col         index of the lowest remaining set bit (0 when empty)
//   empty       no set bits remain
//   last_bit    exactly one set bit remains
module sparse_mask_walker
   import sparse_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [FIELD_W-1:0] load_mask,
   input  logic               pop,
   output logic [COL_W-1:0]   col,
   output logic               empty,
   output logic               last_bit
);

   logic [FIELD_W-1:0] mask_q;
   logic [FIELD_W-1:0] mask_d;
   logic [FIELD_W-1:0] lower_cleared;

   // m & (m-1) drops the lowest set bit; zero result means at most one bit was set.
   assign lower_cleared = mask_q & (mask_q - FIELD_W'(1));
   assign empty         = (mask_q == '0);
   assign last_bit      = !empty && (lower_cleared == '0);

   always_comb begin
      col = '0;
      for (int i = FIELD_W - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            col = COL_W'(i);
         end
      end
   end

   always_comb begin
      mask_d = mask_q;
      if (load) begin
         mask_d = load_mask;
      end else if (pop && !empty) begin
         mask_d = lower_cleared;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q <= '0;
      end else begin
         mask_q <= mask_d;
      end
   end

endmodule

// File: rtl/sparse_row_scheduler.sv
// Sequences one layer of the structured-sparse convolution into the MAC array.
//
// On start, the layer index is registered onto lut_addr; one cycle later the
// returned pointer vector (one 3-bit column mask per kernel row) is captured,
// with fields beyond the layer's field count forced to zero. Each field is
// then walked and one MAC beat is issued per set column bit, lowest first.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   start       one-cycle request to schedule layer_sel
//   layer_sel   layer index sampled with start (legal 1..LAYERS)
//   lut_addr    row-pointer LUT address (holds after the layer)
//   lut_data    LUT pointer vector, field i at bits [3i+2:3i]
//   mac         MAC beat bus (valid/ready, row, col, last)
//   busy        layer in progress
//   done        one-cycle pulse at layer completion
//   err         one-cycle pulse for start with an illegal layer
module sparse_row_scheduler
   import sparse_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [LAYER_W-1:0]     layer_sel,
   output logic [LAYER_W-1:0]     lut_addr,
   input  logic [PTR_W-1:0]       lut_data,
   sparse_row_scheduler_if.master mac,
   output logic                   busy,
   output logic                   done,
   output logic                   err
);

   state_t               state_q, state_d;
   logic [LAYER_W-1:0]   lut_addr_q, lut_addr_d;
   logic [ROW_W-1:0]     count_q, count_d;
   logic [ROW_W-1:0]     field_q, field_d;
   logic [PTR_W-1:0]     rest_q, rest_d;      // fields after the current one, field f+1 at the bottom
   logic                 mac_valid_q, mac_valid_d;
   logic [ROW_W-1:0]     mac_row_q, mac_row_d;
   logic [COL_W-1:0]     mac_col_q, mac_col_d;
   logic                 mac_last_q, mac_last_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   logic [PTR_W-1:0]     masked_data;
   logic                 walk_load, walk_pop;
   logic [FIELD_W-1:0]   walk_mask;
   logic [COL_W-1:0]     walk_col;
   logic                 walk_empty, walk_last_bit;
   logic                 out_free, at_last_field;

   // Zero every field at or beyond the layer's count so stray LUT bits can
   // never produce beats, and so "nothing left" is simply rest_q == 0.
   generate
      for (genvar gi = 0; gi < MAX_FIELDS; gi++) begin : g_field_mask
         assign masked_data[gi*FIELD_W +: FIELD_W] =
            (ROW_W'(gi) < count_q) ? lut_data[gi*FIELD_W +: FIELD_W] : '0;
      end
   endgenerate

   sparse_mask_walker u_walker (
      .clk       (clk),
      .reset     (reset),
      .load      (walk_load),
      .load_mask (walk_mask),
      .pop       (walk_pop),
      .col       (walk_col),
      .empty     (walk_empty),
      .last_bit  (walk_last_bit)
   );

   // The output register can take a new beat when it is empty or its
   // current beat is being accepted this cycle.
   assign out_free      = !mac_valid_q || mac.mac_ready;
   assign at_last_field = (field_q == count_q - ROW_W'(1));

   always_comb begin
      state_d     = state_q;
      lut_addr_d  = lut_addr_q;
      count_d     = count_q;
      field_d     = field_q;
      rest_d      = rest_q;
      mac_valid_d = mac_valid_q;
      mac_row_d   = mac_row_q;
      mac_col_d   = mac_col_q;
      mac_last_d  = mac_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      walk_load   = 1'b0;
      walk_pop    = 1'b0;
      walk_mask   = rest_q[FIELD_W-1:0];

      case (state_q)
         IDLE: begin
            if (start) begin
               if (layer_legal(layer_sel)) begin
                  lut_addr_d = layer_sel;
                  count_d    = field_count(layer_sel);
                  busy_d     = 1'b1;
                  state_d    = FETCH;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         FETCH: begin
            walk_load = 1'b1;
            walk_mask = masked_data[FIELD_W-1:0];
            rest_d    = masked_data >> FIELD_W;
            field_d   = '0;
            state_d   = ISSUE;
         end

         ISSUE: begin
            if (!walk_empty) begin
               if (out_free) begin
                  mac_valid_d = 1'b1;
                  mac_row_d   = field_q;
                  mac_col_d   = walk_col;
                  mac_last_d  = walk_last_bit && (rest_q == '0);
                  walk_pop    = 1'b1;
                  // Move straight to the next field once its final bit is
                  // taken; the last field stays put so DONE can wait for drain.
                  if (walk_last_bit && !at_last_field) begin
                     walk_load = 1'b1;
                     rest_d    = rest_q >> FIELD_W;
                     field_d   = field_q + ROW_W'(1);
                  end
               end
            end else begin
               // Zero field (or last field already exhausted): no new beat.
               if (out_free) begin
                  mac_valid_d = 1'b0;
                  mac_last_d  = 1'b0;
               end
               if (!at_last_field) begin
                  walk_load = 1'b1;
                  rest_d    = rest_q >> FIELD_W;
                  field_d   = field_q + ROW_W'(1);
               end else if (out_free) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         lut_addr_q  <= '0;
         count_q     <= '0;
         field_q     <= '0;
         rest_q      <= '0;
         mac_valid_q <= 1'b0;
         mac_row_q   <= '0;
         mac_col_q   <= '0;
         mac_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         lut_addr_q  <= lut_addr_d;
         count_q     <= count_d;
         field_q     <= field_d;
         rest_q      <= rest_d;
         mac_valid_q <= mac_valid_d;
         mac_row_q   <= mac_row_d;
         mac_col_q   <= mac_col_d;
         mac_last_q  <= mac_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign lut_addr      = lut_addr_q;
   assign mac.mac_valid = mac_valid_q;
   assign mac.mac_row   = mac_row_q;
   assign mac.mac_col   = mac_col_q;
   assign mac.mac_last  = mac_last_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_sparse_row_scheduler.sv
`timescale 1ns/1ps
module tb_sparse_row_scheduler;
   import sparse_pkg::*;

   typedef struct {
      int row;
      int col;
      int last;
   } beat_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [3:0]   layer_sel = 4'd0;
   logic [3:0]   lut_addr;
   logic [215:0] lut_data;
   logic         busy, done, err;
   logic         mac_ready = 1'b1;
   logic         mac_valid;
   logic [6:0]   mac_row;
   logic [1:0]   mac_col;
   logic         mac_last;
   logic [215:0] lut_mem [16];

   sparse_row_scheduler_if mac_bus ();

   assign mac_bus.mac_ready = mac_ready;
   assign mac_valid         = mac_bus.mac_valid;
   assign mac_row           = mac_bus.mac_row;
   assign mac_col           = mac_bus.mac_col;
   assign mac_last          = mac_bus.mac_last;
   assign lut_data          = lut_mem[lut_addr];

   sparse_row_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .layer_sel (layer_sel),
      .lut_addr  (lut_addr),
      .lut_data  (lut_data),
      .mac       (mac_bus),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    beats_seen = 0;
   int    done_cnt = 0;
   int    done_cyc = 0;
   int    err_cnt = 0;
   int    start_cyc = 0;
   bit    ready_rand = 1'b0;
   beat_t exp_q[$];
   int    beat_cyc[$];
   int    cnt_tab[10] = '{0, 1, 36, 36, 36, 72, 72, 72, 36, 36};

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: every set bit of every in-range field, row-major, low column
   // first; the very last one carries mac_last.
   task automatic load_model(input int sel, input logic [215:0] img, output int n);
      beat_t b;
      n = 0;
      for (int f = 0; f < cnt_tab[sel]; f++) begin
         for (int c = 0; c < 3; c++) begin
            if (img[3*f + c]) begin
               b.row = f; b.col = c; b.last = 0;
               exp_q.push_back(b);
               n++;
            end
         end
      end
      if (n > 0) begin
         b = exp_q.pop_back();
         b.last = 1;
         exp_q.push_back(b);
      end
   endtask

   function automatic logic [215:0] rand_img();
      logic [215:0] r;
      r = '0;
      for (int f = 0; f < 72; f++) begin
         if ($urandom_range(0, 1) == 1) r[3*f +: 3] = 3'($urandom_range(0, 7));
      end
      return r;
   endfunction

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // MAC-side ready driver
   initial forever begin
      @(posedge clk);
      #1;
      mac_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor / scoreboard
   bit    stall_pend = 1'b0;
   int    held = 0;
   beat_t mon_e;
   initial forever begin
      @(negedge clk);
      if (reset) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend)
            check("stall_hold", int'({mac_valid, mac_row, mac_col, mac_last}), held);
         if (mac_valid && mac_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat_row", int'(mac_row), -1);
            end else begin
               mon_e = exp_q.pop_front();
               check("beat_row",  int'(mac_row),  mon_e.row);
               check("beat_col",  int'(mac_col),  mon_e.col);
               check("beat_last", int'(mac_last), mon_e.last);
            end
            beat_cyc.push_back(cyc);
            beats_seen++;
         end
         stall_pend = mac_valid && !mac_ready;
         held = int'({mac_valid, mac_row, mac_col, mac_last});
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("queue_empty_at_done", exp_q.size(), 0);
            check("busy_at_done", int'(busy), 1);
         end
         if (err) err_cnt++;
      end
   end

   task automatic pulse_start(input int sel);
      @(posedge clk); #1;
      start = 1'b1;
      layer_sel = 4'(sel);
      @(posedge clk); #1;
      start = 1'b0;
      start_cyc = cyc;
   endtask

   task automatic run_layer(input int sel, input logic [215:0] img, input bit rnd,
                            input bit disturb, output int nexp);
      int d0, b0, e0;
      lut_mem[sel] = img;
      ready_rand = rnd;
      load_model(sel, img, nexp);
      d0 = done_cnt; b0 = beats_seen; e0 = err_cnt;
      beat_cyc.delete();
      pulse_start(sel);
      if (disturb) begin
         repeat (4) @(posedge clk);
         check("busy_before_restart", int'(busy), 1);
         pulse_start(5);
         pulse_start(0);
      end
      for (int i = 0; i < 4000 && done_cnt == d0; i++) @(posedge clk);
      check("done_pulses", done_cnt - d0, 1);
      @(negedge clk);
      check("busy_after_done", int'(busy), 0);
      check("done_one_cycle", int'(done), 0);
      check("beat_count", beats_seen - b0, nexp);
      check("lut_addr_held", int'(lut_addr), sel);
      check("err_during_run", err_cnt - e0, 0);
      $display("layer %0d: expected %0d beats, saw %0d, random ready %0d",
               sel, nexp, beats_seen - b0, rnd);
   endtask

   logic [215:0] img;
   int           n, b0;
   int           bad_sel[2] = '{0, 12};

   initial begin
      for (int i = 0; i < 16; i++) lut_mem[i] = '0;

      // reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_lut_addr",  int'(lut_addr),  0);
      check("rst_mac_valid", int'(mac_valid), 0);
      check("rst_mac_row",   int'(mac_row),   0);
      check("rst_mac_col",   int'(mac_col),   0);
      check("rst_mac_last",  int'(mac_last),  0);
      check("rst_busy",      int'(busy),      0);
      check("rst_done",      int'(done),      0);
      check("rst_err",       int'(err),       0);
      @(posedge clk); #1;
      reset = 1'b0;

      // layer 1, single field 011
      img = '0; img[2:0] = 3'b011;
      run_layer(1, img, 1'b0, 1'b0, n);
      if (beat_cyc.size() == 2) begin
         check("l1_first_latency", beat_cyc[0] - start_cyc, 2);
         check("l1_done_after_last", done_cyc - beat_cyc[1], 1);
      end else begin
         check("l1_beat_list", beat_cyc.size(), 2);
      end

      // layer 8: 36 fields of 001, out-of-range fields full of ones
      img = '0;
      for (int f = 0; f < 72; f++) img[3*f +: 3] = (f < 36) ? 3'b001 : 3'b111;
      run_layer(8, img, 1'b0, 1'b0, n);

      // layer 5: 72 fields of 011 with random backpressure
      img = '0;
      for (int f = 0; f < 72; f++) img[3*f +: 3] = 3'b011;
      run_layer(5, img, 1'b1, 1'b0, n);

      // zero-field gap: field 0 = 101, fields 1,2 = 000, field 3 = 110
      img = rand_img();
      img[2:0] = 3'b101; img[5:3] = 3'b000; img[8:6] = 3'b000; img[11:9] = 3'b110;
      run_layer(2, img, 1'b0, 1'b0, n);
      if (beat_cyc.size() >= 3) begin
         check("gap_first_latency", beat_cyc[0] - start_cyc, 2);
         check("gap_two_idle_cycles", beat_cyc[2] - beat_cyc[1], 3);
      end else begin
         check("gap_beat_list", beat_cyc.size(), n);
      end

      // illegal layers
      ready_rand = 1'b0;
      foreach (bad_sel[k]) begin
         b0 = beats_seen;
         pulse_start(bad_sel[k]);
         @(negedge clk);
         check("err_pulse", int'(err), 1);
         check("busy_on_err", int'(busy), 0);
         @(negedge clk);
         check("err_one_cycle", int'(err), 0);
         check("busy_after_err", int'(busy), 0);
         check("no_beat_on_err", beats_seen - b0, 0);
         $display("illegal layer %0d: err seen, no beats", bad_sel[k]);
      end

      // restart attempts while layer 2 is busy
      img = rand_img();
      img[2:0] = 3'b111;
      run_layer(2, img, 1'b1, 1'b1, n);

      // all-zero layer completes with no beats
      run_layer(4, '0, 1'b0, 1'b0, n);

      // random layers, images and backpressure
      for (int r = 0; r < 6; r++) begin
         run_layer(int'($urandom_range(1, 9)), rand_img(), 1'($urandom_range(0, 1)), 1'b0, n);
      end

      // reset mid-issue of layer 6
      img = '0;
      for (int f = 0; f < 72; f++) img[3*f +: 3] = 3'b111;
      lut_mem[6] = img;
      ready_rand = 1'b1;
      load_model(6, img, n);
      b0 = beats_seen;
      pulse_start(6);
      for (int i = 0; i < 2000 && (beats_seen - b0) < 50; i++) @(posedge clk);
      check("beats_before_reset", int'((beats_seen - b0) >= 50), 1);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midrst_mac_valid", int'(mac_valid), 0);
      check("midrst_busy",      int'(busy),      0);
      check("midrst_lut_addr",  int'(lut_addr),  0);
      check("midrst_mac_last",  int'(mac_last),  0);
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      $display("layer 6: reset after %0d beats", beats_seen - b0);

      // fresh layer 1 after reset
      img = '0; img[2:0] = 3'b011;
      run_layer(1, img, 1'b0, 1'b0, n);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got %0d vectors, expected completion", n_vec);
      $fatal(1);
   end

endmodule

// File: doc/sparse_row_scheduler.md
Name: sparse_row_scheduler

Overview:
- Sequences one layer of the structured-sparse convolution through the MAC datapath.
- For the selected layer, it drives the row-pointer LUT address and latches the returned pointer vector of 3-bit kernel-row masks.
- It then walks each mask and issues one MAC beat per non-zero kernel column, skipping pruned weights.
- Sits between the layer sequencer (start/done) and the MAC array (valid/ready).

Parameters:
- MAX_FIELDS, 72, maximum 3-bit mask fields per layer; pointer bus width is 3*MAX_FIELDS = 216.
- FIELD_W, 3, mask bits per field, one per kernel column.
- LAYERS, 9, highest legal layer index; legal layers are 1..LAYERS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to schedule layer_sel.
- layer_sel  in  4  layer index, sampled with start.
- lut_addr  out  4  address to the row-pointer LUT.
- lut_data  in  216  LUT pointer vector, zero-extended to 216 bits; field i is bits [3i+2:3i].
- mac_valid  out  1  a MAC beat is presented.
- mac_ready  in  1  MAC array accepts the beat.
- mac_row  out  7  field (kernel row) index of the beat, 0..MAX_FIELDS-1.
- mac_col  out  2  kernel column of the beat, 0..2.
- mac_last  out  1  beat is the final non-zero of the layer.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the layer completes.
- err  out  1  one-cycle pulse when start carries an illegal layer.

Behaviour:
- Reset values: lut_addr=0, mac_valid=0, mac_row=0, mac_col=0, mac_last=0, busy=0, done=0, err=0. State is IDLE.
- Field count per layer is a constant table: layer 1→1; layers 2,3,4→36; layers 5,6,7→72; layers 8,9→36.
- IDLE:
  - start with layer_sel in 1..9: register lut_addr=layer_sel and the field count, go to FETCH, set busy.
  - start with layer_sel of 0 or >9: err pulses the next cycle; stay in IDLE.
- FETCH (1 cycle): lut_data is combinational off lut_addr. At the end of this cycle, latch lut_data into the mask register, clear the field index, go to ISSUE.
- ISSUE, for current field f with mask m:
  - m≠0: mac_valid=1, mac_row=f, mac_col=index of the lowest set bit of m.
  - On a handshake (mac_valid & mac_ready), clear that bit. When the last set bit is consumed, advance f.
  - m=000: one cycle with mac_valid=0, then advance f.
  - Without mac_ready, mac_valid, mac_row and mac_col hold stable. No beat is dropped or duplicated.
  - mac_last=1 only on the beat with the final set bit of the last field that has any set bit.
  - After the last field (f = count-1) is finished, go to DONE. A layer whose masks are all zero reaches DONE with no beats issued.
- DONE (1 cycle): done=1, busy falls the next cycle, return to IDLE. lut_addr holds its last value.
- Latency: start accepted at edge T; the first mac_valid is in the cycle after edge T+2, if field 0 is non-zero.
- start while busy is ignored: no err, no restart.
- reset asserted mid-layer returns to IDLE next edge with all outputs at reset values. Pending beats are discarded.
- Beat count per layer equals the popcount of the valid fields. Fields at or beyond the field count are ignored even if lut_data bits there are non-zero.

Decomposition:
- Shared package sparse_pkg holds:
  - FIELD_W, MAX_FIELDS, LAYERS;
  - the per-layer field-count function (layer → count);
  - the state enum (IDLE, FETCH, ISSUE, DONE).
- One natural sub-module, sparse_mask_walker: given a 3-bit mask and a pop handshake, it outputs the lowest set column, empty and last-bit flags.
- The field-index counter and FSM stay in the top.

Test Plan:
- Layer 1, LUT returns 011, mac_ready=1: beats (row0,col0), (row0,col1 with mac_last=1); done pulses 1 cycle later; 2 beats total.
- Layer 8, 36 fields of 001, mac_ready=1: 36 beats with col=0 and rows 0..35; mac_last only on row 35; done once.
- Layer 5, 72 fields of 011 with mac_ready toggled pseudo-randomly: exactly 144 beats in row-major order; outputs stable while stalled.
- Force a LUT image with fields 1 and 2 = 000 and field 0 = 101: beats (0,0), (0,2), then 2 idle cycles with mac_valid low, then field 3 beats resume.
- start with layer_sel=0 and with layer_sel=12: err pulses, busy stays 0, no beats. A second start during a busy layer-2 run has no effect.
- Assert reset mid-issue of layer 6 (after 50 beats): next cycle mac_valid=0, busy=0. A fresh start of layer 1 then produces the 2 expected beats.
